// File: rtl/sprite_line_scheduler_pkg.sv
// Shared constants, FSM states and slot record layout for the sprite line scheduler.
// The slot record is packed as {x, row, id}; its width depends on the object id width.
package sprite_line_scheduler_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned ROW_W       = 5;
    localparam int unsigned SPRITE_SIZE = 32;
    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic int unsigned slot_rec_w(input int unsigned idw);
        return COORD_W + ROW_W + idw;
    endfunction

endpackage

// File: rtl/sprite_hit_test.sv
// Vertical intersection test for one object: does scanline y fall inside the sprite,
// and which sprite row does it hit. Shared with the renderer bounds check.
module sprite_hit_test
    import sprite_line_scheduler_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] obj_y,
    input  logic               en,
    output logic               hit,
    output logic [ROW_W-1:0]   row
);

    logic [COORD_W:0] y_end;

    // Bottom edge kept one bit wider so objects near the bottom of the range do not wrap.
    always_comb begin
        y_end = {1'b0, obj_y} + (COORD_W+1)'(SIZE);
        hit   = en && (y >= obj_y) && ({1'b0, y} < y_end);
        row   = ROW_W'(y - obj_y);
    end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: scans the object table during hblank and loads up to
// SLOTS intersecting sprites into slot registers that stay stable for the display line.
module sprite_line_scheduler
    import sprite_line_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 16,
    parameter int unsigned SLOTS       = 4,
    parameter int unsigned SPRITE_SIZE = sprite_line_scheduler_pkg::SPRITE_SIZE,
    parameter int unsigned IDW         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       line_start,
    input  logic [COORD_W-1:0]         next_y,
    output logic [IDW-1:0]             obj_addr,
    input  logic [COORD_W-1:0]         obj_x,
    input  logic [COORD_W-1:0]         obj_y,
    input  logic                       obj_en,
    output logic [SLOTS-1:0]           slot_valid,
    output logic [COORD_W*SLOTS-1:0]   slot_x,
    output logic [ROW_W*SLOTS-1:0]     slot_row,
    output logic [IDW*SLOTS-1:0]       slot_id,
    output logic                       done,
    output logic                       overflow,
    output logic                       busy
);

    localparam int unsigned CNT_W = $clog2(SLOTS + 1);
    localparam int unsigned SCW   = $clog2(NUM_SPRITES + 1);
    localparam int unsigned REC_W = slot_rec_w(IDW);

    state_t               state, state_next;
    logic [SCW-1:0]       scan_cnt;
    logic [CNT_W-1:0]     hit_cnt;
    logic                 ovf_sh;
    logic [COORD_W-1:0]   y_l;
    logic [REC_W-1:0]     shadow [SLOTS];

    logic                 hit;
    logic [ROW_W-1:0]     hit_row;
    logic                 eval_en;
    logic                 scan_last;
    logic [IDW-1:0]       eval_id;

    sprite_hit_test #(
        .SIZE (SPRITE_SIZE)
    ) u_hit (
        .y     (y_l),
        .obj_y (obj_y),
        .en    (obj_en),
        .hit   (hit),
        .row   (hit_row)
    );

    // Entry k is addressed while scan_cnt == k and evaluated one cycle later.
    assign obj_addr = scan_cnt[IDW-1:0];

    always_comb begin
        eval_en   = (state == ST_SCAN) && (scan_cnt != '0);
        scan_last = (scan_cnt == SCW'(NUM_SPRITES));
        eval_id   = IDW'(scan_cnt - SCW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (line_start) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (line_start)     state_next = ST_SCAN;
                else if (scan_last) state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                done       = 1'b1;
                state_next = line_start ? ST_SCAN : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Commit and restart are independent: a line_start during COMMIT still publishes the
    // finished line from the old shadow while the new scan clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_l        <= '0;
            scan_cnt   <= '0;
            hit_cnt    <= '0;
            ovf_sh     <= 1'b0;
            slot_valid <= '0;
            slot_x     <= '0;
            slot_row   <= '0;
            slot_id    <= '0;
            overflow   <= 1'b0;
            for (int unsigned i = 0; i < SLOTS; i++) shadow[i] <= '0;
        end else begin
            if (state == ST_COMMIT) begin
                for (int unsigned i = 0; i < SLOTS; i++) begin
                    slot_x[COORD_W*i +: COORD_W] <= shadow[i][REC_W-1 -: COORD_W];
                    slot_row[ROW_W*i +: ROW_W]   <= shadow[i][IDW +: ROW_W];
                    slot_id[IDW*i +: IDW]        <= shadow[i][IDW-1:0];
                    slot_valid[i]                <= (CNT_W'(i) < hit_cnt);
                end
                overflow <= ovf_sh;
            end

            if (line_start) begin
                y_l      <= next_y;
                scan_cnt <= '0;
                hit_cnt  <= '0;
                ovf_sh   <= 1'b0;
                for (int unsigned i = 0; i < SLOTS; i++) shadow[i] <= '0;
            end else if (state == ST_SCAN) begin
                if (!scan_last) scan_cnt <= scan_cnt + SCW'(1);
                if (eval_en && hit) begin
                    if (hit_cnt < CNT_W'(SLOTS)) begin
                        for (int unsigned i = 0; i < SLOTS; i++) begin
                            if (CNT_W'(i) == hit_cnt) shadow[i] <= {obj_x, hit_row, eval_id};
                        end
                        hit_cnt <= hit_cnt + CNT_W'(1);
                    end else begin
                        ovf_sh <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed self-checking bench for sprite_line_scheduler with a 1-cycle object-table RAM model.
module tb_sprite_line_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic [9:0]  next_y = '0;
    logic [3:0]  obj_addr;
    logic [9:0]  obj_x, obj_y;
    logic        obj_en;
    logic [3:0]  slot_valid;
    logic [39:0] slot_x;
    logic [19:0] slot_row;
    logic [15:0] slot_id;
    logic        done, overflow, busy;

    logic [9:0]  tb_x  [16];
    logic [9:0]  tb_y  [16];
    logic        tb_en [16];

    int tests  = 0;
    int failed = 0;
    int lat, n, dones, first;

    sprite_line_scheduler #(
        .NUM_SPRITES (16),
        .SLOTS       (4),
        .SPRITE_SIZE (32),
        .IDW         (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .next_y     (next_y),
        .obj_addr   (obj_addr),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_en     (obj_en),
        .slot_valid (slot_valid),
        .slot_x     (slot_x),
        .slot_row   (slot_row),
        .slot_id    (slot_id),
        .done       (done),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        obj_x  <= tb_x[obj_addr];
        obj_y  <= tb_y[obj_addr];
        obj_en <= tb_en[obj_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 16; i++) begin
            tb_x[i]  = '0;
            tb_y[i]  = '0;
            tb_en[i] = 1'b0;
        end
    endtask

    // Pulse line_start, wait (bounded) for done, then step to the first valid-output cycle.
    task automatic run_line(input logic [9:0] y, output int l);
        next_y     = y;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        l = 1;
        while (!done && l < 40) begin
            tick();
            l++;
        end
        tick();
    endtask

    initial begin
        clear_table();

        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_valid", slot_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", obj_addr, 0);
        rst = 1'b0;
        tick();

        // Basic select
        tb_y[2] = 10'd100; tb_x[2] = 10'd50;  tb_en[2] = 1'b1;
        tb_y[7] = 10'd90;  tb_x[7] = 10'd300; tb_en[7] = 1'b1;
        next_y = 10'd105;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("basic_busy", busy, 1);
        chk("basic_addr0", obj_addr, 0);
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk("basic_lat", lat, 18);
        tick();
        chk("basic_valid", slot_valid, 4'b0011);
        chk("basic_x", slot_x, {10'd0, 10'd0, 10'd300, 10'd50});
        chk("basic_row", slot_row, {5'd0, 5'd0, 5'd15, 5'd5});
        chk("basic_id", slot_id, {4'd0, 4'd0, 4'd7, 4'd2});
        chk("basic_ovf", overflow, 0);
        chk("basic_idle", busy, 0);

        // Boundary rows
        clear_table();
        tb_y[0] = 10'd200; tb_x[0] = 10'd123; tb_en[0] = 1'b1;
        run_line(10'd200, lat);
        chk("row0_valid", slot_valid, 4'b0001);
        chk("row0_row", slot_row, 20'd0);
        chk("row0_x", slot_x, 40'd123);
        run_line(10'd231, lat);
        chk("row31_valid", slot_valid, 4'b0001);
        chk("row31_row", slot_row, {5'd0, 5'd0, 5'd0, 5'd31});
        run_line(10'd232, lat);
        chk("row32_lat", lat, 18);
        chk("row32_valid", slot_valid, 0);
        run_line(10'd199, lat);
        chk("rowm1_lat", lat, 18);
        chk("rowm1_valid", slot_valid, 0);

        // Overflow
        clear_table();
        tb_en[1] = 1'b1;  tb_x[1] = 10'd10;
        tb_en[3] = 1'b1;  tb_x[3] = 10'd30;
        tb_en[4] = 1'b1;  tb_x[4] = 10'd40;
        tb_en[8] = 1'b1;  tb_x[8] = 10'd80;
        tb_en[9] = 1'b1;  tb_x[9] = 10'd90;
        tb_en[15] = 1'b1; tb_x[15] = 10'd150;
        run_line(10'd10, lat);
        chk("ovf_valid", slot_valid, 4'b1111);
        chk("ovf_id", slot_id, {4'd8, 4'd4, 4'd3, 4'd1});
        chk("ovf_row", slot_row, {5'd10, 5'd10, 5'd10, 5'd10});
        chk("ovf_x", slot_x, {10'd80, 10'd40, 10'd30, 10'd10});
        chk("ovf_flag", overflow, 1);
        clear_table();
        run_line(10'd10, lat);
        chk("ovf_clear", overflow, 0);
        chk("ovf_clear_valid", slot_valid, 0);

        // Restart mid-scan
        clear_table();
        tb_y[5] = 10'd40; tb_x[5] = 10'd500; tb_en[5] = 1'b1;
        tb_y[6] = 10'd55; tb_x[6] = 10'd600; tb_en[6] = 1'b1;
        next_y = 10'd50;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (4) tick();
        next_y = 10'd60;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        n = 1; dones = 0; first = 0;
        repeat (30) begin
            if (done) begin
                dones++;
                if (first == 0) first = n;
            end
            tick();
            n++;
        end
        chk("restart_dones", dones, 1);
        chk("restart_lat", first, 18);
        chk("restart_valid", slot_valid, 4'b0011);
        chk("restart_id", slot_id, {4'd0, 4'd0, 4'd6, 4'd5});
        chk("restart_row", slot_row, {5'd0, 5'd0, 5'd5, 5'd20});

        // No wrap near the bottom of the coordinate range
        clear_table();
        tb_y[3] = 10'd1010; tb_x[3] = 10'd7; tb_en[3] = 1'b1;
        run_line(10'd5, lat);
        chk("nowrap_valid", slot_valid, 0);
        run_line(10'd1020, lat);
        chk("high_valid", slot_valid, 4'b0001);
        chk("high_row", slot_row, {5'd0, 5'd0, 5'd0, 5'd10});
        chk("high_id", slot_id, {4'd0, 4'd0, 4'd0, 4'd3});

        // Stability: table changes after commit do not reach the slots
        clear_table();
        tb_y[2] = 10'd100; tb_x[2] = 10'd50; tb_en[2] = 1'b1;
        run_line(10'd105, lat);
        tb_x[2] = 10'd999; tb_en[2] = 1'b0; tb_y[9] = 10'd100; tb_en[9] = 1'b1;
        dones = 0;
        repeat (20) begin
            if (done) dones++;
            tick();
        end
        chk("stable_dones", dones, 0);
        chk("stable_x", slot_x, 40'd50);
        chk("stable_valid", slot_valid, 4'b0001);

        // Reset mid-scan drops the scan and clears outputs
        next_y = 10'd105;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dones = 0;
        repeat (25) begin
            if (done) dones++;
            tick();
        end
        chk("rstscan_dones", dones, 0);
        chk("rstscan_valid", slot_valid, 0);
        chk("rstscan_x", slot_x, 0);
        chk("rstscan_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
